// File: rtl/sr_lut_pixel_writeback_pkg.sv
// Shared widths and lane arithmetic for the Y-channel LUT writeback stage.
package sr_lut_pixel_writeback_pkg;

    localparam int PIX_W        = 8;
    localparam int SUM_W        = 11;
    localparam int LANES        = 4;
    localparam int WEIGHT_SHIFT = 3;
    localparam int ROUND_BIAS   = 4;
    localparam int WORD_W       = PIX_W * LANES;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              eol;
        logic              eof;
    } fifo_word_t;

    // Normalise one weighted sum (round half up), add to the centre pixel, clamp to 0..255.
    function automatic logic [PIX_W-1:0] lane_px(input logic [PIX_W-1:0] c,
                                                 input logic signed [SUM_W-1:0] sum);
        logic signed [SUM_W-1:0] r;
        logic signed [PIX_W+1:0] s;
        r = sum + $signed(SUM_W'(ROUND_BIAS));
        r = r >>> WEIGHT_SHIFT;
        s = $signed({2'b00, c}) + $signed(r[PIX_W+1:0]);
        if (s[PIX_W+1])
            lane_px = '0;
        else if (s[PIX_W])
            lane_px = '1;
        else
            lane_px = s[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/sr_lut_wb_fifo.sv
// Synchronous FIFO for packed pixel words; no fall-through, write+read allowed when full.
module sr_lut_wb_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 34,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic [W-1:0]  wr_data_i,
    output logic          wr_ok_o,
    input  logic          rd_en_i,
    output logic [W-1:0]  rd_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          rd_ok;

    assign full_o   = (count_q == (AW+1)'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    // A read frees the slot the write needs, so full+read+write is legal.
    assign wr_ok_o  = wr_en_i & (~full_o | rd_en_i);
    assign rd_ok    = rd_en_i & ~empty_o;
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({wr_ok_o, rd_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok_o)
            mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok_o) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok)   rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sr_lut_pixel_writeback.sv
// Aligns centre pixels with interpolator sums, clamps 4 sub-pixels, tags line/frame
// position and buffers the packed words behind a credit-based input handshake.
module sr_lut_pixel_writeback
    import sr_lut_pixel_writeback_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  center,
    input  logic [SUM_W-1:0]  out1,
    input  logic [SUM_W-1:0]  out2,
    input  logic [SUM_W-1:0]  out3,
    input  logic [SUM_W-1:0]  out4,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [WORD_W-1:0] pix_data,
    output logic              pix_eol,
    output logic              pix_eof
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic accept;
    assign accept = in_valid & in_ready;

    // Centre pixel rides alongside the interpolator so it meets out1..out4 at the tap.
    logic [LAT:1]            vld_pipe_q;
    logic [LAT:1][PIX_W-1:0] ctr_pipe_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe_q <= '0;
            ctr_pipe_q <= '0;
        end else begin
            vld_pipe_q[1] <= accept;
            ctr_pipe_q[1] <= center;
            for (int i = 2; i <= LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                ctr_pipe_q[i] <= ctr_pipe_q[i-1];
            end
        end
    end

    logic [LANES-1:0][SUM_W-1:0] sums;
    logic [LANES-1:0][PIX_W-1:0] px_d;
    assign sums = {out1, out2, out3, out4};

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign px_d[k] = lane_px(ctr_pipe_q[LAT], $signed(sums[k]));
    end

    logic              wb_vld_q;
    logic [WORD_W-1:0] wb_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_vld_q  <= 1'b0;
            wb_data_q <= '0;
        end else begin
            wb_vld_q <= vld_pipe_q[LAT];
            if (vld_pipe_q[LAT])
                wb_data_q <= px_d;
        end
    end

    logic          wr_ok, fifo_full, fifo_empty;
    logic [AW:0]   fifo_count;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          eol, eof;
    fifo_word_t    wr_word, rd_word;

    assign eol     = (col_q == CW'(IMG_W - 1));
    assign eof     = eol & (row_q == RW'(IMG_H - 1));
    assign wr_word = '{data: wb_data_q, eol: eol, eof: eof};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (wr_ok) begin
            col_q <= eol ? '0 : col_q + CW'(1);
            if (eof)
                row_q <= '0;
            else if (eol)
                row_q <= row_q + RW'(1);
        end
    end

    sr_lut_wb_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fifo_word_t))
    ) u_fifo (
        .clk_i     (clk),
        .rst_ni    (rst),
        .wr_en_i   (wb_vld_q),
        .wr_data_i (wr_word),
        .wr_ok_o   (wr_ok),
        .rd_en_i   (pix_ready),
        .rd_data_o (rd_word),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign pix_valid = ~fifo_empty;
    assign pix_data  = rd_word.data;
    assign pix_eol   = rd_word.eol;
    assign pix_eof   = rd_word.eof;

    // Every accepted pixel holds a FIFO slot from issue until its write.
    logic [AW:0]   inflight_q, inflight_d;
    logic [AW+1:0] credit;

    assign credit   = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign in_ready = (credit < (AW+2)'(DEPTH));

    always_comb begin
        inflight_d = inflight_q;
        case ({accept, wb_vld_q})
            2'b10:   inflight_d = inflight_q + (AW+1)'(1);
            2'b01:   inflight_d = inflight_q - (AW+1)'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    logic ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            if (wb_vld_q & fifo_full & ~pix_ready)
                ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sr_lut_pixel_writeback.sv
// Directed bench for the LUT pixel writeback stage: arithmetic, latency, flags, credit, reset.
module tb_sr_lut_pixel_writeback;

    localparam int LAT   = 2;
    localparam int DEPTH = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  center = 8'd0;
    logic [10:0] out1, out2, out3, out4;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [31:0] pix_data;
    logic        pix_eol, pix_eof;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Interpolator model: sums of an accepted pixel appear LAT cycles later.
    logic [43:0] st_sum = '0;
    logic [43:0] lat_sum = '0;
    logic [43:0] d1, dq;
    assign {out1, out2, out3, out4} = dq;

    int          acc_cyc[$];
    logic [31:0] got_data[$];
    logic        got_eol[$];
    logic        got_eof[$];
    int          got_cyc[$];

    sr_lut_pixel_writeback #(
        .LAT(LAT), .DEPTH(DEPTH), .IMG_W(IMG_W), .IMG_H(IMG_H)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .center(center),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_eol(pix_eol), .pix_eof(pix_eof)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            d1 <= '0;
            dq <= '0;
        end else begin
            d1 <= lat_sum;
            dq <= d1;
        end
    end

    always @(negedge clk) begin
        lat_sum = (rst && in_valid && in_ready) ? st_sum : '0;
        if (rst && in_valid && in_ready)
            acc_cyc.push_back(cyc);
        if (rst && pix_valid && pix_ready) begin
            got_data.push_back(pix_data);
            got_eol.push_back(pix_eol);
            got_eof.push_back(pix_eof);
            got_cyc.push_back(cyc);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        pix_ready = 1'b0;
        st_sum    = '0;
        rst       = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(1);
    endtask

    task automatic send(input logic [7:0] c, input int s1, input int s2, input int s3,
                        input int s4, output bit ok);
        in_valid = 1'b1;
        center   = c;
        st_sum   = {11'(s1), 11'(s2), 11'(s3), 11'(s4)};
        ok = 1'b0;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget, output bit ok);
        for (int k = 0; k < budget && got_data.size() < n; k++) idle(1);
        ok = (got_data.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle(2);
        checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL reset_pix_valid got=%b want=0", pix_valid); end
        checks++; if (pix_data !== 32'h0) begin failures++; $display("FAIL reset_pix_data got=%h want=0", pix_data); end
        checks++; if (pix_eol !== 1'b0 || pix_eof !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b want=00", pix_eol, pix_eof); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        rst = 1'b1;
        idle(4);
        checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL idle_pix_valid got=%b want=0", pix_valid); end
    endtask

    task automatic test_latency();
        bit ok, okw;
        int b, ab;
        do_reset();
        pix_ready = 1'b1;
        b = got_data.size();
        ab = acc_cyc.size();
        send(8'd100, 80, 80, 80, 80, ok);
        wait_words(b + 1, 20, okw);
        checks++;
        if (!ok || !okw) begin
            failures++; $display("FAIL latency_timeout accepted=%0b word=%0b want=1,1", ok, okw);
        end else begin
            checks++; if (got_data[b] !== 32'h6E6E6E6E) begin failures++; $display("FAIL basic_data got=%h want=6e6e6e6e", got_data[b]); end
            checks++; if (got_cyc[b] - acc_cyc[ab] != LAT + 2) begin failures++; $display("FAIL basic_latency got=%0d want=%0d", got_cyc[b] - acc_cyc[ab], LAT + 2); end
        end
    endtask

    task automatic test_clamp();
        logic [7:0]  vc [4] = '{8'd10, 8'd50, 8'd250, 8'd0};
        int          vs [4][4] = '{'{-1016, 1016, -4, 3}, '{12, -12, -13, 11},
                                   '{80, -1016, 1016, -80}, '{-80, -1016, 4, 1016}};
        logic [31:0] exp [4] = '{32'h00890A0A, 32'h34313033, 32'hFF7BFFF0, 32'h0000017F};
        bit ok, okw, all_ok;
        int b;
        do_reset();
        pix_ready = 1'b1;
        b = got_data.size();
        all_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(vc[i], vs[i][0], vs[i][1], vs[i][2], vs[i][3], ok);
            all_ok &= ok;
        end
        wait_words(b + 4, 20, okw);
        checks++;
        if (!all_ok || !okw) begin
            failures++; $display("FAIL clamp_timeout accepted=%0b words=%0d want=4", all_ok, got_data.size() - b);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_data[b+i] !== exp[i]) begin failures++; $display("FAIL clamp_vec%0d got=%h want=%h", i, got_data[b+i], exp[i]); end
            end
        end
    endtask

    task automatic test_position();
        bit ok, okw, all_ok;
        int b;
        logic [7:0] c;
        do_reset();
        pix_ready = 1'b1;
        b = got_data.size();
        all_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(8'(i + 1), 0, 0, 0, 0, ok);
            all_ok &= ok;
        end
        wait_words(b + 12, 30, okw);
        checks++;
        if (!all_ok || !okw) begin
            failures++; $display("FAIL pos_timeout accepted=%0b words=%0d want=12", all_ok, got_data.size() - b);
        end else begin
            for (int i = 0; i < 12; i++) begin
                c = 8'(i + 1);
                checks++;
                if (got_data[b+i] !== {4{c}}) begin failures++; $display("FAIL pos_data%0d got=%h want=%h", i, got_data[b+i], {4{c}}); end
                checks++;
                if (got_eol[b+i] !== ((i % IMG_W) == IMG_W - 1)) begin failures++; $display("FAIL pos_eol%0d got=%b want=%b", i, got_eol[b+i], (i % IMG_W) == IMG_W - 1); end
                checks++;
                if (got_eof[b+i] !== (i == IMG_W * IMG_H - 1)) begin failures++; $display("FAIL pos_eof%0d got=%b want=%b", i, got_eof[b+i], i == IMG_W * IMG_H - 1); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok, okw, all_ok, stuck_low;
        int b, ab;
        do_reset();
        b = got_data.size();
        ab = acc_cyc.size();
        all_ok = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            send(8'(8'h10 + i), 0, 0, 0, 0, ok);
            all_ok &= ok;
        end
        in_valid = 1'b1;
        center   = 8'hEE;
        st_sum   = '0;
        stuck_low = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (in_ready !== 1'b0) stuck_low = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++; if (!all_ok) begin failures++; $display("FAIL bp_fill_accept got=0 want=1"); end
        checks++; if (!stuck_low) begin failures++; $display("FAIL bp_in_ready got=1 want=0 while full"); end
        checks++; if (acc_cyc.size() - ab != DEPTH) begin failures++; $display("FAIL bp_accepts got=%0d want=%0d", acc_cyc.size() - ab, DEPTH); end
        checks++; if (dut.u_fifo.count_q != DEPTH) begin failures++; $display("FAIL bp_count got=%0d want=%0d", dut.u_fifo.count_q, DEPTH); end
        checks++; if (dut.ovf_q !== 1'b0) begin failures++; $display("FAIL bp_ovf got=%b want=0", dut.ovf_q); end
        pix_ready = 1'b1;
        wait_words(b + DEPTH, 30, okw);
        idle(5);
        checks++;
        if (!okw || got_data.size() != b + DEPTH) begin
            failures++; $display("FAIL bp_drain_words got=%0d want=%0d", got_data.size() - b, DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (got_data[b+i] !== {4{8'(8'h10 + i)}} || got_cyc[b+i] != got_cyc[b] + i) begin
                    failures++; $display("FAIL bp_drain%0d got=%h@%0d want=%h@%0d", i, got_data[b+i], got_cyc[b+i], {4{8'(8'h10 + i)}}, got_cyc[b] + i);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok, okw, all_ok, in_order, dense, acc_dense;
        int b, ab;
        do_reset();
        b = got_data.size();
        ab = acc_cyc.size();
        all_ok = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            send(8'(8'h80 + i), 0, 0, 0, 0, ok);
            all_ok &= ok;
        end
        idle(4);
        checks++; if (dut.u_fifo.count_q != DEPTH) begin failures++; $display("FAIL b2b_prefill got=%0d want=%0d", dut.u_fifo.count_q, DEPTH); end
        pix_ready = 1'b1;
        for (int i = DEPTH; i < DEPTH + 16; i++) begin
            send(8'(8'h80 + i), 0, 0, 0, 0, ok);
            all_ok &= ok;
        end
        wait_words(b + DEPTH + 16, 60, okw);
        checks++;
        if (!all_ok || !okw) begin
            failures++; $display("FAIL b2b_timeout accepted=%0b words=%0d want=%0d", all_ok, got_data.size() - b, DEPTH + 16);
        end else begin
            in_order = 1'b1;
            dense = 1'b1;
            acc_dense = 1'b1;
            for (int i = 0; i < DEPTH + 16; i++) begin
                if (got_data[b+i] !== {4{8'(8'h80 + i)}}) in_order = 1'b0;
                if (got_cyc[b+i] != got_cyc[b] + i) dense = 1'b0;
            end
            for (int i = 0; i < 16; i++)
                if (acc_cyc[ab+DEPTH+i] != acc_cyc[ab+DEPTH] + i) acc_dense = 1'b0;
            checks++; if (!in_order) begin failures++; $display("FAIL b2b_order got=out-of-order want=in-order"); end
            checks++; if (!dense) begin failures++; $display("FAIL b2b_out_rate got=gaps want=1 word/cycle"); end
            checks++; if (!acc_dense) begin failures++; $display("FAIL b2b_in_rate got=gaps want=1 accept/cycle"); end
        end
        checks++; if (dut.ovf_q !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%b want=0", dut.ovf_q); end
    endtask

    task automatic test_reset_midflight();
        bit ok, okw, all_ok;
        int b;
        do_reset();
        all_ok = 1'b1;
        for (int i = 0; i < DEPTH / 2; i++) begin
            send(8'(8'h21 + i), 0, 0, 0, 0, ok);
            all_ok &= ok;
        end
        idle(4);
        for (int i = 0; i < 3; i++) begin
            send(8'(8'h31 + i), 40, 40, 40, 40, ok);
            all_ok &= ok;
        end
        rst = 1'b0;
        #1;
        checks++; if (!all_ok) begin failures++; $display("FAIL mid_setup_accept got=0 want=1"); end
        checks++; if (pix_valid !== 1'b0 || pix_data !== 32'h0) begin failures++; $display("FAIL mid_rst_out got=%b/%h want=0/0", pix_valid, pix_data); end
        checks++; if (pix_eol !== 1'b0 || pix_eof !== 1'b0) begin failures++; $display("FAIL mid_rst_flags got=%b%b want=00", pix_eol, pix_eof); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_in_ready got=%b want=1", in_ready); end
        #2;
        rst = 1'b1;
        idle(1);
        b = got_data.size();
        pix_ready = 1'b1;
        idle(6);
        checks++; if (got_data.size() != b) begin failures++; $display("FAIL mid_stale_words got=%0d want=0", got_data.size() - b); end
        send(8'h5A, 0, 0, 0, 0, ok);
        wait_words(b + 1, 20, okw);
        idle(6);
        checks++;
        if (!ok || !okw || got_data.size() != b + 1) begin
            failures++; $display("FAIL mid_after_words got=%0d want=1", got_data.size() - b);
        end else begin
            checks++; if (got_data[b] !== 32'h5A5A5A5A || got_eol[b] !== 1'b0) begin failures++; $display("FAIL mid_first_word got=%h eol=%b want=5a5a5a5a eol=0", got_data[b], got_eol[b]); end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_clamp();
        test_position();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
